// File: rtl/seg7_pkg.sv
// Seven-segment helpers shared by the display path.
// Holds the active-high gfedcba glyph patterns (seg[0]=a .. seg[6]=g) and
// the BCD-to-glyph decode function used by bcd_to_seg7.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Invalid BCD codes (10..15) show a dash so a counter fault is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high seven-segment pattern.
// Ports:
//   digit  in  4  BCD digit (10..15 decode as a dash)
//   seg    out 7  active-high gfedcba pattern, seg[0]=a
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = bcd_to_seg(digit);

endmodule

// File: rtl/bcd_display_mux.sv
// Two-digit multiplexed seven-segment driver for a 00..99 BCD counter.
// A refresh counter alternates the units/tens slots every REFRESH_DIV
// cycles; both digits are snapshotted together at each frame start so a
// frame never mixes old and new digits. seg/an are registered.
// Ports:
//   clock       in  1  system clock, rising edge
//   reset       in  1  synchronous active-high reset
//   count_high  in  4  BCD tens digit
//   count_low   in  4  BCD units digit
//   enable      in  1  1 = display on, 0 = all anodes inactive
//   seg         out 7  segment drive, seg[0]=a .. seg[6]=g
//   an          out 2  anode select, an[0]=units, an[1]=tens
module bcd_display_mux
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV        = 50000,
  parameter bit SEG_ACTIVE_LOW     = 1'b1,
  parameter bit AN_ACTIVE_LOW      = 1'b1,
  parameter bit BLANK_LEADING_ZERO = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] count_high,
  input  logic [3:0] count_low,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [1:0]       AN_OFF   = AN_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  logic [CNT_W-1:0] cnt_r;
  logic             digit_sel_r;   // 0 = units slot, 1 = tens slot
  logic [3:0]       latch_high_r;
  logic [3:0]       latch_low_r;
  logic [6:0]       seg_r;
  logic [1:0]       an_r;

  logic             wrap_s;
  logic [3:0]       digit_s;
  logic [6:0]       pattern_s;
  logic             lit_s;
  logic [1:0]       onehot_s;
  logic [1:0]       an_next_s;
  logic [6:0]       seg_next_s;

  assign wrap_s = (cnt_r == CNT_LAST);

  // Single decoder on the currently selected latched digit.
  bcd_to_seg7 u_dec (
    .digit (digit_s),
    .seg   (pattern_s)
  );

  // Digit mux, blanking decision and output polarity.
  always_comb begin
    digit_s    = latch_low_r;
    lit_s      = enable;
    onehot_s   = 2'b00;
    an_next_s  = AN_OFF;
    seg_next_s = SEG_OFF;

    if (digit_sel_r) begin
      digit_s = latch_high_r;
    end else begin
      digit_s = latch_low_r;
    end

    if (digit_sel_r && BLANK_LEADING_ZERO && (latch_high_r == 4'd0)) begin
      lit_s = 1'b0;
    end else begin
      lit_s = enable;
    end

    if (lit_s) begin
      onehot_s = digit_sel_r ? 2'b10 : 2'b01;
    end else begin
      onehot_s = 2'b00;
    end

    if (AN_ACTIVE_LOW) begin
      an_next_s = ~onehot_s;
    end else begin
      an_next_s = onehot_s;
    end

    // Segments stay dark whenever the selected anode is off.
    if (SEG_ACTIVE_LOW) begin
      seg_next_s = lit_s ? ~pattern_s : ~SEG_BLANK;
    end else begin
      seg_next_s = lit_s ? pattern_s : SEG_BLANK;
    end
  end

  // Refresh counter, slot select, frame latch and registered pins.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r        <= {CNT_W{1'b0}};
      digit_sel_r  <= 1'b0;
      latch_high_r <= 4'd0;
      latch_low_r  <= 4'd0;
      an_r         <= AN_OFF;
      seg_r        <= SEG_OFF;
    end else begin
      an_r  <= an_next_s;
      seg_r <= seg_next_s;
      if (wrap_s) begin
        cnt_r       <= {CNT_W{1'b0}};
        digit_sel_r <= ~digit_sel_r;
        // End of the tens slot is the frame boundary: capture both digits.
        if (digit_sel_r) begin
          latch_high_r <= count_high;
          latch_low_r  <= count_low;
        end
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign seg = seg_r;
  assign an  = an_r;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench for bcd_display_mux (REFRESH_DIV=4, active-low pins).
// Two instances share stimulus: one with leading-zero blanking, one without.
// Expected pin values come from a frame/slot model driven by the number of
// cycles since reset.
module tb_bcd_display_mux;

  localparam int DIV = 4;

  logic       clock;
  logic       reset;
  logic [3:0] count_high;
  logic [3:0] count_low;
  logic       enable;
  logic [6:0] seg_b, seg_n;
  logic [1:0] an_b, an_n;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] an_b;
    logic [6:0] seg_b;
    logic [1:0] an_n;
    logic [6:0] seg_n;
  } exp_t;

  exp_t q[$];

  // Reference model state
  int         t_m;
  logic [3:0] mh, ml;
  logic [6:0] glyph [16];

  bcd_display_mux #(
    .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1),
    .BLANK_LEADING_ZERO(1'b1)
  ) dut_blank (
    .clock(clock), .reset(reset), .count_high(count_high),
    .count_low(count_low), .enable(enable), .seg(seg_b), .an(an_b)
  );

  bcd_display_mux #(
    .REFRESH_DIV(DIV), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1),
    .BLANK_LEADING_ZERO(1'b0)
  ) dut_noblank (
    .clock(clock), .reset(reset), .count_high(count_high),
    .count_low(count_low), .enable(enable), .seg(seg_n), .an(an_n)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected pins for the current model state with the given blanking mode.
  function automatic logic [8:0] model_out(input logic en, input logic blz);
    logic       tens;
    logic [3:0] d;
    logic       lit;
    tens = (((t_m / DIV) % 2) == 1);
    d    = tens ? mh : ml;
    lit  = en && !(tens && blz && (mh == 4'd0));
    if (!lit) return {2'b11, 7'h7F};
    return {(tens ? 2'b01 : 2'b10), ~glyph[d]};
  endfunction

  task automatic step(input logic r, input logic [3:0] h, input logic [3:0] l,
                      input logic e, input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      reset      = r;
      count_high = h;
      count_low  = l;
      enable     = e;
      if (r) begin
        x   = {2'b11, 7'h7F, 2'b11, 7'h7F};
        t_m = 0;
        mh  = 4'd0;
        ml  = 4'd0;
      end else begin
        x = {model_out(e, 1'b1), model_out(e, 1'b0)};
        // Last cycle of the tens slot: the frame boundary samples inputs.
        if ((t_m % (2 * DIV)) == (2 * DIV - 1)) begin
          mh = h;
          ml = l;
        end
        t_m++;
      end
      q.push_back(x);
      @(posedge clock);
      #2;
    end
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (time %0t)", name, got, want, $time);
    end
  endtask

  // Monitor: one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("an_blank",    {5'd0, an_b},  {5'd0, e.an_b});
        check("seg_blank",   seg_b,         e.seg_b);
        check("an_noblank",  {5'd0, an_n},  {5'd0, e.an_n});
        check("seg_noblank", seg_n,         e.seg_n);
      end
    end
  end

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    t_m = 0;
    mh  = 4'd0;
    ml  = 4'd0;

    // Reset with inputs present, then first frame shows latched 00.
    step(1'b1, 4'd4, 4'd7, 1'b1, 3);
    step(1'b0, 4'd4, 4'd7, 1'b1, 24);
    // Mid-frame input change is deferred to the next frame.
    step(1'b0, 4'd4, 4'd7, 1'b1, 2);
    step(1'b0, 4'd4, 4'd8, 1'b1, 14);
    // Leading zero tens, then invalid BCD units.
    step(1'b0, 4'd0, 4'd5, 1'b1, 16);
    step(1'b0, 4'd3, 4'hC, 1'b1, 16);
    // Enable drop mid-slot and resume.
    step(1'b0, 4'd2, 4'd9, 1'b1, 3);
    step(1'b0, 4'd2, 4'd9, 1'b0, 3);
    step(1'b0, 4'd2, 4'd9, 1'b1, 12);
    // Reset pulse mid-frame.
    step(1'b0, 4'd6, 4'd1, 1'b1, 5);
    step(1'b1, 4'd6, 4'd1, 1'b1, 1);
    step(1'b0, 4'd6, 4'd1, 1'b1, 20);
    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 60) == 0, 4'($urandom % 16), 4'($urandom % 16),
           ($urandom % 8) != 0, 1);
    end

    @(posedge clock);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d entries want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
